// File: rtl/priority_encoder_if.sv
// ---------------------------------------------------------------------------
// priority_encoder_if : input/output handshake bundle for priority_encoder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface priority_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d;
  logic       out_valid;
  logic       out_ready;
  logic       a;
  logic       b;
  logic       none;
  logic       err;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, a, b, none, err
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, a, b, none, err
  );
endinterface

`default_nettype wire

// File: rtl/priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder : registered 4-to-2 priority encoder, 2-entry output FIFO.
// Optional macro PRIORITY_ENCODER_ONEHOT_CHECK_EN enables multi-hot err flag.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module priority_encoder (
  input wire logic          clk,
  input wire logic          rst_n,
  priority_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_live;
  logic [3:0] r_head;
  logic [3:0] r_tail;
  logic [3:0] w_entry;
  logic [1:0] w_code;
  logic       w_none;
  logic       w_err;
  logic       w_push;
  logic       w_pop;
  logic       w_in_ready;
  logic       w_out_valid;

  always_comb begin
    w_code = 2'b00;
    if (bus.d[3])      w_code = 2'b11;
    else if (bus.d[2]) w_code = 2'b10;
    else if (bus.d[1]) w_code = 2'b01;
  end

  assign w_none = (bus.d == 4'b0000);

`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
  // clearing the lowest set bit leaves something only for multi-hot words
  assign w_err = |(bus.d & (bus.d - 4'd1));
`else
  assign w_err = 1'b0;
`endif

  assign w_entry = {w_code, w_none, w_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_EMPTY: w_in_ready = r_live;
      S_ONE: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
      end
      S_FULL:  w_out_valid = 1'b1;
      default: ;
    endcase
    w_push = bus.in_valid && w_in_ready;
    w_pop  = w_out_valid && bus.out_ready;
    case (r_state)
      S_EMPTY: if (w_push) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = S_FULL;
        else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_pop) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // r_live holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_head <= 4'b0000;
      r_tail <= 4'b0000;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_EMPTY: if (w_push) r_head <= w_entry;
        S_ONE: begin
          if (w_push && w_pop) r_head <= w_entry;
          else if (w_push)     r_tail <= w_entry;
        end
        S_FULL:  if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign {bus.a, bus.b, bus.none, bus.err} = w_out_valid ? r_head : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder : directed + random bench with a queue-based reference.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_priority_encoder;

`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
  localparam bit C_ERR_EN = 1'b1;
`else
  localparam bit C_ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  priority_encoder_if ifc ();

  priority_encoder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference entry {code[1:0], none, err} from the encoding rules
  function automatic logic [3:0] ref_enc(input logic [3:0] d);
    int idx;
    int ones;
    idx  = 0;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        idx = i;
        ones++;
      end
    end
    return {idx[1:0], (d == 4'b0000), (C_ERR_EN && ones > 1)};
  endfunction

  logic [3:0] q[$];
  bit         alive;

  always @(negedge rst_n) begin
    q.delete();
    alive = 1'b0;
  end

  always @(posedge clk) begin
    bit exp_rdy;
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      q.delete();
      alive = 1'b0;
    end else begin
      exp_rdy = alive && (q.size() < 2);
      do_push = ifc.in_valid && exp_rdy;
      do_pop  = (q.size() > 0) && ifc.out_ready;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(ref_enc(ifc.d));
      alive = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    e = (q.size() > 0) ? q[0] : 4'b0000;
    chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, (alive && q.size() < 2)});
    chk("out_valid", {31'd0, ifc.out_valid}, {31'd0, (q.size() > 0)});
    chk("out_entry", {28'd0, ifc.a, ifc.b, ifc.none, ifc.err}, {28'd0, e});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_check(input string name, input logic [3:0] d,
                            input logic [1:0] exp_ab, input bit exp_none, input bit exp_err);
    logic [3:0] dec;
    ifc.in_valid  = 1'b1;
    ifc.d         = d;
    ifc.out_ready = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    chk({name, "_valid"}, {31'd0, ifc.out_valid}, 32'd1);
    chk({name, "_ab"}, {30'd0, ifc.a, ifc.b}, {30'd0, exp_ab});
    chk({name, "_none"}, {31'd0, ifc.none}, {31'd0, exp_none});
    chk({name, "_err"}, {31'd0, ifc.err}, {31'd0, exp_err});
    if (!exp_none && !exp_err && $countones(d) == 1) begin
      dec = 4'b0001 << {ifc.a, ifc.b};
      chk({name, "_roundtrip"}, {28'd0, dec}, {28'd0, d});
    end
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.d         = 4'b0000;
    ifc.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    chk("rst_outs", {27'd0, ifc.out_valid, ifc.a, ifc.b, ifc.none, ifc.err}, 32'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    step();
    chk("rel_in_ready_high", {31'd0, ifc.in_ready}, 32'd1);

    push_check("oh0", 4'b0001, 2'b00, 1'b0, 1'b0);
    push_check("oh1", 4'b0010, 2'b01, 1'b0, 1'b0);
    push_check("oh2", 4'b0100, 2'b10, 1'b0, 1'b0);
    push_check("oh3", 4'b1000, 2'b11, 1'b0, 1'b0);
    push_check("zero", 4'b0000, 2'b00, 1'b1, 1'b0);
    push_check("mh1010", 4'b1010, 2'b11, 1'b0, C_ERR_EN);
    push_check("mh0110", 4'b0110, 2'b10, 1'b0, C_ERR_EN);
    push_check("mh0101", 4'b0101, 2'b10, 1'b0, C_ERR_EN);
    step();
    chk("drain_empty", {31'd0, ifc.out_valid}, 32'd0);

    // Backpressure: third word must be refused until after the first pop
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.d         = 4'b0001;
    step();
    chk("bp_rdy_one", {31'd0, ifc.in_ready}, 32'd1);
    ifc.d = 4'b0010;
    step();
    chk("bp_rdy_full", {31'd0, ifc.in_ready}, 32'd0);
    ifc.d = 4'b0100;
    step();
    chk("bp_still_full", {31'd0, ifc.in_ready}, 32'd0);
    chk("bp_head0", {30'd0, ifc.a, ifc.b}, 32'd0);
    ifc.out_ready = 1'b1;
    step();
    chk("bp_head1", {30'd0, ifc.a, ifc.b}, 32'd1);
    chk("bp_rdy_back", {31'd0, ifc.in_ready}, 32'd1);
    step();
    ifc.in_valid = 1'b0;
    chk("bp_head2", {30'd0, ifc.a, ifc.b}, 32'd2);
    chk("bp_valid2", {31'd0, ifc.out_valid}, 32'd1);
    step();
    chk("bp_empty", {31'd0, ifc.out_valid}, 32'd0);

    // Simultaneous push/pop in ONE
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.d         = 4'b1000;
    step();
    ifc.d         = 4'b0001;
    ifc.out_ready = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    chk("pp_head", {30'd0, ifc.a, ifc.b}, 32'd0);
    chk("pp_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("pp_rdy", {31'd0, ifc.in_ready}, 32'd1);
    step();
    chk("pp_empty", {31'd0, ifc.out_valid}, 32'd0);

    // Reset mid-stream from FULL
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.d         = 4'b1000;
    step();
    ifc.d = 4'b0100;
    step();
    ifc.in_valid = 1'b0;
    chk("mr_full", {31'd0, ifc.in_ready}, 32'd0);
    chk("mr_head", {30'd0, ifc.a, ifc.b}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_outs", {27'd0, ifc.out_valid, ifc.a, ifc.b, ifc.none, ifc.err}, 32'd0);
    chk("mr_async_rdy", {31'd0, ifc.in_ready}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("mr_rel_rdy", {31'd0, ifc.in_ready}, 32'd1);
    chk("mr_rel_empty", {31'd0, ifc.out_valid}, 32'd0);
    push_check("mr_fresh", 4'b0010, 2'b01, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = 1'($urandom_range(0, 1));
      ifc.d         = 4'($urandom);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_encoder.md
# priority_encoder

Registered 4-to-2 priority encoder: the inverse of the team's 2-to-4 decoder. It accepts a 4-bit line word over a valid/ready handshake and returns the 2-bit index `{a,b}` of the highest set line, together with status flags. Results pass through a 2-entry output buffer, so an upstream source can stream one word per cycle while downstream applies backpressure. It sits wherever a decoded line set must be turned back into a binary select.

## Interface
Parameters:
- none; widths are fixed at 4 lines in and 2 code bits out.

Ports:
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `in_valid` — input, 1 — `d` holds a word to encode.
- `in_ready` — output, 1 — block can accept a word this cycle.
- `d` — input, 4 — line word; bit i set means line i active.
- `out_valid` — output, 1 — the head buffer entry is presented on `a`, `b`, `none`, `err`.
- `out_ready` — input, 1 — downstream consumes the head entry this cycle.
- `a` — output, 1 — code MSB.
- `b` — output, 1 — code LSB.
- `none` — output, 1 — encoded word was 4'b0000.
- `err` — output, 1 — encoded word had more than one bit set (see Configuration).

## Operation
- **Encoding** (highest index wins):
  - `d[3]` → `{a,b}=11`
  - else `d[2]` → `10`
  - else `d[1]` → `01`
  - else `d[0]` → `00`
  - `d==0` → `{a,b}=00`, `none=1`
- **Round-trip:** for a one-hot `d`, the team's decoder applied to `{a,b}` reproduces `d`.
- **Push:** occurs when `in_valid && in_ready`. The encoded entry `{a,b,none,err}` is written to the buffer tail.
- **Pop:** occurs when `out_valid && out_ready`. The head is removed.
- **Buffer:** 2-entry FIFO with a state machine on occupancy:
  - `EMPTY`: `out_valid=0`, `in_ready=1`.
    - push → `ONE`.
  - `ONE`: `out_valid=1`, `in_ready=1`.
    - push only → `FULL`
    - pop only → `EMPTY`
    - push and pop together → stay in `ONE`; the new entry becomes head next cycle.
  - `FULL`: `out_valid=1`, `in_ready=0`.
    - pop → `ONE`
    - `in_valid` is ignored.
- **Registered ready:** `in_ready` is a function of state only. It never depends combinationally on `out_ready`, so no push is accepted in `FULL` even if a pop happens in the same cycle.
- **Output stability:** `a`, `b`, `none` and `err` are driven from the head entry. They hold stable while `out_valid=1 && out_ready=0`.
- **Don't-care outputs:** when `out_valid=0`, `a`, `b`, `none` and `err` are don't-care for the consumer, but are driven 0.
- **Reset:** asserting `rst_n=0` at any time, including mid-stream, clears the state to `EMPTY`, discards buffered entries, and forces every output to its reset value.

## Timing
- **Reset values:** `in_ready=0` while `rst_n=0`; `out_valid=0`, `a=0`, `b=0`, `none=0`, `err=0`.
- **Release from reset:** `in_ready` rises on the first `clk` edge after `rst_n` deasserts (state `EMPTY`).
- **Latency:** 1 cycle. A word pushed at edge N is presented with `out_valid=1` after edge N.
- **Throughput:** 1 word/cycle sustained while `out_ready=1`.
- **Ordering:** FIFO order is preserved; no entry is dropped or duplicated.
- **Backpressure:** with `out_ready=0` held, exactly two words are accepted, then `in_ready=0`. It rises again the cycle after the first pop.

## Configuration
- **`PRIORITY_ENCODER_ONEHOT_CHECK_EN` defined:**
  - `err=1` for any `d` with two or more bits set.
  - Encoding still follows priority, e.g. `d=0101` gives `{a,b}=10`, `err=1`.
- **Macro not defined:**
  - The check logic is not compiled.
  - `err` is tied to 0.
  - Multi-hot words are encoded by priority silently.

## Test plan
- **Exhaustive one-hot:** push `d` = `0001`, `0010`, `0100`, `1000` with `out_ready=1` → `{a,b}` = `00`, `01`, `10`, `11`, each 1 cycle after acceptance; `none=0`, `err=0`; decoder round-trip equals `d`.
- **Zero and multi-hot:**
  - push `0000` → `{a,b}=00`, `none=1`.
  - push `1010` → `{a,b}=11`.
  - push `0110` → `{a,b}=10`.
  - With the macro defined, `err=1` on `1010` and `0110`; without it, `err=0`.
- **Backpressure:** `out_ready=0`, offer `0001`, `0010`, `0100` back-to-back → first two accepted, `in_ready=0` on the third. Then raise `out_ready` → outputs `00`, `01`, then `10` is accepted and emitted, in order.
- **Simultaneous push/pop in `ONE`:** one entry held, `in_valid=1`, `out_ready=1` → occupancy stays 1 and the new word is at the head next cycle.
- **Reset mid-stream:** `FULL` with entries `11`, `10`; pulse `rst_n=0` between clock edges → `out_valid`, `a`, `b`, `none`, `err` go 0 immediately, without waiting for a clock edge. After release the buffer is empty and the next push yields a fresh result.
